// File: rtl/uart_rx_frontend_if.sv
// Byte-stream port of uart_rx_frontend: one-entry valid/ready buffer plus
// the three one-cycle error strobes. The master side is the receiver.
interface uart_rx_frontend_if;
  logic [7:0] DATA;
  logic       VALID;
  logic       READY;
  logic       FRAME_ERR;
  logic       OVERRUN;
  logic       PARITY_ERR;

  modport master (
    output DATA,
    output VALID,
    input  READY,
    output FRAME_ERR,
    output OVERRUN,
    output PARITY_ERR
  );

  modport slave (
    input  DATA,
    input  VALID,
    output READY,
    input  FRAME_ERR,
    input  OVERRUN,
    input  PARITY_ERR
  );
endinterface

// File: rtl/uart_rx_frontend.sv
// UART receive front-end: synchronises RXD, deframes 8N1 (8E1 when
// UART_RX_PARITY_EN is defined) and hands bytes over a one-entry valid/ready buffer.
module uart_rx_frontend #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                RXD,
  uart_rx_frontend_if.master  rx
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  // The counter runs down to zero, so loads are one less than the interval.
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

`ifdef UART_RX_PARITY_EN
  localparam state_t ST_AFTER_DATA = ST_PARITY;
`else
  localparam state_t ST_AFTER_DATA = ST_STOP;
`endif

  state_t           state, state_nxt;
  logic             rxd_meta, rxs;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             frame_err_q;
  logic             overrun_q;
  logic             tick;
  logic             handshake;

  logic load_half, load_bit, shift_en, bit_clr;
  logic deliver, frame_err_set;

`ifdef UART_RX_PARITY_EN
  logic par_err, par_sample, parity_err_set, parity_err_q;
`endif

  assign tick      = (cnt == '0);
  assign handshake = valid_q && rx.READY;

  // ---------------------------------------------------------------------
  // Input synchroniser; both flops reset to the idle line level so that
  // reset release never looks like a start edge.
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rxd_meta <= 1'b1;
      rxs      <= 1'b1;
    end else begin
      rxd_meta <= RXD;
      rxs      <= rxd_meta;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (!rxs) state_nxt = ST_START;
      ST_START:     if (tick) state_nxt = rxs ? ST_IDLE : ST_DATA;
      ST_DATA:      if (tick && bit_cnt == 3'd7) state_nxt = ST_AFTER_DATA;
`ifdef UART_RX_PARITY_EN
      ST_PARITY:    if (tick) state_nxt = ST_STOP;
`endif
      ST_STOP:      if (tick) state_nxt = rxs ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (rxs) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: output decode (counter control, sampling strobes, delivery)
  // ---------------------------------------------------------------------
  always_comb begin
    load_half      = 1'b0;
    load_bit       = 1'b0;
    shift_en       = 1'b0;
    bit_clr        = 1'b0;
    deliver        = 1'b0;
    frame_err_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_sample     = 1'b0;
    parity_err_set = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        bit_clr = 1'b1;
        if (!rxs) load_half = 1'b1;
      end
      ST_START: begin
        if (tick && !rxs) load_bit = 1'b1;
      end
      ST_DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          load_bit = 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          par_sample = 1'b1;
          load_bit   = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        // A low stop bit wins over a parity mismatch.
        if (tick) begin
          if (!rxs)         frame_err_set  = 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (par_err) parity_err_set = 1'b1;
`endif
          else              deliver        = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Baud counter and bit counter
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt <= '0;
    end else if (load_half) begin
      cnt <= HALF_LOAD;
    end else if (load_bit) begin
      cnt <= BIT_LOAD;
    end else if (!tick) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)        bit_cnt <= 3'd0;
    else if (bit_clr)  bit_cnt <= 3'd0;
    else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
  end

  // LSB arrives first, so shift in from the top.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)        shreg <= 8'h00;
    else if (shift_en) shreg <= {rxs, shreg[7:1]};
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: the parity bit equals the XOR of the data bits.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)          par_err <= 1'b0;
    else if (par_sample) par_err <= (rxs != ^shreg);
  end
`endif

  // ---------------------------------------------------------------------
  // One-entry output buffer and error strobes
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (deliver) begin
        if (!valid_q || handshake) begin
          data_q  <= shreg;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (handshake) begin
        valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_err_set;
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) parity_err_q <= 1'b0;
    else        parity_err_q <= parity_err_set;
  end
  assign rx.PARITY_ERR = parity_err_q;
`else
  assign rx.PARITY_ERR = 1'b0;
`endif

  assign rx.DATA      = data_q;
  assign rx.VALID     = valid_q;
  assign rx.FRAME_ERR = frame_err_q;
  assign rx.OVERRUN   = overrun_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend at CLKS_PER_BIT=16; covers 8N1 by default
// and 8E1 when UART_RX_PARITY_EN is defined.
module tb_uart_rx_frontend;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit TB_PAR = 1'b1;
`else
  localparam bit TB_PAR = 1'b0;
`endif

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  logic RXD   = 1'b1;

  uart_rx_frontend_if rx_if();

  uart_rx_frontend #(.CLKS_PER_BIT(CPB)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .RXD   (RXD),
    .rx    (rx_if.master)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Event counters gathered by the monitor, cleared per scenario.
  int         valid_cycles = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         pe_cnt = 0;
  int         stab_err = 0;
  logic [7:0] acc_q[$];
  logic       prev_valid = 1'b0;
  logic       prev_hs    = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge CLK) begin
    if (RESET) begin
      if (rx_if.VALID)                acc_dummy();
      if (rx_if.VALID)                valid_cycles++;
      if (rx_if.VALID && rx_if.READY) acc_q.push_back(rx_if.DATA);
      if (rx_if.FRAME_ERR)            fe_cnt++;
      if (rx_if.OVERRUN)              ov_cnt++;
      if (rx_if.PARITY_ERR)           pe_cnt++;
      if (prev_valid && !prev_hs && rx_if.DATA !== prev_data) stab_err++;
    end
    prev_valid = rx_if.VALID;
    prev_hs    = rx_if.VALID && rx_if.READY;
    prev_data  = rx_if.DATA;
  end

  function automatic void acc_dummy();
  endfunction

  task automatic clear_counts();
    valid_cycles = 0;
    fe_cnt       = 0;
    ov_cnt       = 0;
    pe_cnt       = 0;
    stab_err     = 0;
    acc_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Drives one frame starting at the current negedge; the parity bit is the
  // correct even parity unless force_par selects par_val.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic force_par, input logic par_val);
    RXD = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      idle(CPB);
    end
    if (TB_PAR) begin
      RXD = force_par ? par_val : ^b;
      idle(CPB);
    end
    RXD = stop_bit;
    idle(CPB);
    RXD = 1'b1;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    RXD   = 1'b1;
    rx_if.READY = 1'b1;
    idle(3);
    RESET = 1'b1;
    idle(2);
    checks++; if (rx_if.DATA !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rx_if.DATA); end
    checks++; if (rx_if.VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_if.VALID); end
    checks++; if (rx_if.FRAME_ERR !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", rx_if.FRAME_ERR); end
    checks++; if (rx_if.OVERRUN !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", rx_if.OVERRUN); end
    checks++; if (rx_if.PARITY_ERR !== 1'b0) begin failures++; $display("FAIL reset_parity_err got=%b exp=0", rx_if.PARITY_ERR); end
  endtask

  task automatic test_basic();
    clear_counts();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    idle(20);
    checks++; if (valid_cycles != 1) begin failures++; $display("FAIL basic_valid_cycles got=%0d exp=1", valid_cycles); end
    checks++; if (acc_q.size() != 1) begin failures++; $display("FAIL basic_accepted got=%0d exp=1", acc_q.size()); end
    checks++; if (rx_if.DATA !== 8'hA5) begin failures++; $display("FAIL basic_data got=%h exp=a5", rx_if.DATA); end
    checks++; if (fe_cnt + ov_cnt + pe_cnt != 0) begin failures++; $display("FAIL basic_errors got fe=%0d ov=%0d pe=%0d exp=0", fe_cnt, ov_cnt, pe_cnt); end
    checks++; if (stab_err != 0) begin failures++; $display("FAIL basic_stability got=%0d exp=0", stab_err); end
  endtask

  task automatic test_false_start();
    clear_counts();
    RXD = 1'b0;
    idle(4);
    RXD = 1'b1;
    idle(3 * CPB);
    checks++; if (valid_cycles != 0) begin failures++; $display("FAIL false_start_valid got=%0d exp=0", valid_cycles); end
    checks++; if (fe_cnt + ov_cnt + pe_cnt != 0) begin failures++; $display("FAIL false_start_errors got fe=%0d ov=%0d pe=%0d exp=0", fe_cnt, ov_cnt, pe_cnt); end
  endtask

  task automatic test_frame_error();
    clear_counts();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    RXD = 1'b0;
    idle(3 * CPB);
    RXD = 1'b1;
    idle(CPB);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    idle(20);
    checks++; if (fe_cnt != 1) begin failures++; $display("FAIL frame_err_pulses got=%0d exp=1", fe_cnt); end
    checks++; if (acc_q.size() != 1) begin failures++; $display("FAIL frame_err_accepted got=%0d exp=1", acc_q.size()); end
    checks++; if (valid_cycles != 1) begin failures++; $display("FAIL frame_err_valid_cycles got=%0d exp=1", valid_cycles); end
    checks++; if (rx_if.DATA !== 8'h81) begin failures++; $display("FAIL frame_err_data got=%h exp=81", rx_if.DATA); end
    checks++; if (ov_cnt + pe_cnt != 0) begin failures++; $display("FAIL frame_err_other got ov=%0d pe=%0d exp=0", ov_cnt, pe_cnt); end
  endtask

  task automatic test_back_to_back();
    @(posedge CLK); #1 rx_if.READY = 1'b0;
    @(negedge CLK);
    clear_counts();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    idle(20);
    checks++; if (rx_if.VALID !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", rx_if.VALID); end
    checks++; if (rx_if.DATA !== 8'h11) begin failures++; $display("FAIL b2b_data_held got=%h exp=11", rx_if.DATA); end
    checks++; if (ov_cnt != 1) begin failures++; $display("FAIL b2b_overrun got=%0d exp=1", ov_cnt); end
    checks++; if (acc_q.size() != 0) begin failures++; $display("FAIL b2b_accepted_early got=%0d exp=0", acc_q.size()); end
    checks++; if (stab_err != 0) begin failures++; $display("FAIL b2b_stability got=%0d exp=0", stab_err); end
    @(posedge CLK); #1 rx_if.READY = 1'b1;
    @(posedge CLK); #1;
    checks++; if (rx_if.VALID !== 1'b0) begin failures++; $display("FAIL b2b_valid_after_hs got=%b exp=0", rx_if.VALID); end
    checks++;
    if (acc_q.size() != 1) begin
      failures++; $display("FAIL b2b_handshake got_count=%0d exp_count=1", acc_q.size());
    end else if (acc_q[0] !== 8'h11) begin
      failures++; $display("FAIL b2b_handshake got=%h exp=11", acc_q[0]);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'h5A;
    clear_counts();
    RXD = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      RXD = b[i];
      idle(CPB);
    end
    RXD = b[4];
    idle(CPB / 2);
    RESET = 1'b0;
    #1;
    checks++; if (rx_if.DATA !== 8'h00) begin failures++; $display("FAIL midrst_data got=%h exp=00", rx_if.DATA); end
    checks++; if (rx_if.VALID !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", rx_if.VALID); end
    checks++; if (rx_if.FRAME_ERR !== 1'b0) begin failures++; $display("FAIL midrst_frame_err got=%b exp=0", rx_if.FRAME_ERR); end
    checks++; if (rx_if.OVERRUN !== 1'b0) begin failures++; $display("FAIL midrst_overrun got=%b exp=0", rx_if.OVERRUN); end
    checks++; if (rx_if.PARITY_ERR !== 1'b0) begin failures++; $display("FAIL midrst_parity_err got=%b exp=0", rx_if.PARITY_ERR); end
    RXD = 1'b1;
    idle(4);
    RESET = 1'b1;
    idle(2 * CPB);
    checks++; if (valid_cycles != 0) begin failures++; $display("FAIL midrst_release_valid got=%0d exp=0", valid_cycles); end
    checks++; if (fe_cnt + ov_cnt + pe_cnt != 0) begin failures++; $display("FAIL midrst_release_errors got fe=%0d ov=%0d pe=%0d exp=0", fe_cnt, ov_cnt, pe_cnt); end
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    idle(20);
    checks++; if (acc_q.size() != 1) begin failures++; $display("FAIL midrst_accepted got=%0d exp=1", acc_q.size()); end
    checks++; if (rx_if.DATA !== 8'h5A) begin failures++; $display("FAIL midrst_data_after got=%h exp=5a", rx_if.DATA); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_counts();
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    idle(20);
    checks++; if (pe_cnt != 1) begin failures++; $display("FAIL parity_bad_pulses got=%0d exp=1", pe_cnt); end
    checks++; if (valid_cycles != 0) begin failures++; $display("FAIL parity_bad_valid got=%0d exp=0", valid_cycles); end
    checks++; if (fe_cnt != 0) begin failures++; $display("FAIL parity_bad_frame_err got=%0d exp=0", fe_cnt); end
    clear_counts();
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    idle(20);
    checks++; if (pe_cnt != 0) begin failures++; $display("FAIL parity_good_pulses got=%0d exp=0", pe_cnt); end
    checks++; if (acc_q.size() != 1) begin failures++; $display("FAIL parity_good_accepted got=%0d exp=1", acc_q.size()); end
    checks++; if (rx_if.DATA !== 8'h07) begin failures++; $display("FAIL parity_good_data got=%h exp=07", rx_if.DATA); end
  endtask
`else
  // Without parity the PARITY_ERR output must never move.
  task automatic test_parity();
    checks++; if (pe_cnt != 0) begin failures++; $display("FAIL parity_tied got=%0d exp=0", pe_cnt); end
  endtask
`endif

  initial begin
    rx_if.READY = 1'b1;
    test_reset();
    test_basic();
    test_false_start();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
